// File: rtl/ipu_pkg.sv
// Shared image-pipeline definitions: writeback FSM encoding, lane geometry, tag fields and
// the pending-pixel record used by pixel_writeback_packer.
package ipu_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 2;
  localparam int unsigned H_W    = 9;
  localparam int unsigned V_W    = 9;
  localparam int unsigned COL_W  = H_W - LANE_W;
  localparam int unsigned TAG_W  = V_W + COL_W;

  localparam logic [1:0] StAccum = 2'd0;
  localparam logic [1:0] StReq   = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [LANE_W-1:0] lane;
    logic [7:0]        pix;
  } pend_t;

  function automatic logic [8*LANES-1:0] lane_insert(input logic [8*LANES-1:0] word,
                                                     input logic [LANE_W-1:0]  lane,
                                                     input logic [7:0]         pix);
    logic [8*LANES-1:0] r;
    r = word;
    r[{lane, 3'b000} +: 8] = pix;
    return r;
  endfunction

endpackage

// File: rtl/pixel_clamp.sv
// Converts a signed convolution result to an 8-bit pixel by clamping to 0..255.
// Define PIXEL_WB_ABS_EN to take the absolute value first (edge-magnitude output).
module pixel_clamp (
  input  logic signed [15:0] pix_in,
  output logic        [7:0]  pix_out
);

  logic signed [16:0] ext;

  always_comb begin
    ext = {pix_in[15], pix_in};
`ifdef PIXEL_WB_ABS_EN
    // 17 bits so that -32768 negates to a positive value.
    if (ext[16]) ext = -ext;
`else
    ext = ext;
`endif
    if (ext[16]) begin
      pix_out = 8'h00;
    end else if (ext > 17'sd255) begin
      pix_out = 8'hFF;
    end else begin
      pix_out = ext[7:0];
    end
  end

endmodule

// File: rtl/pixel_writeback_packer.sv
// Packs clamped pixels into 32-bit words and writes them through a shared, arbitrated
// frame-memory port. Macro PIXEL_WB_ABS_EN (via pixel_clamp) selects abs-before-clamp.
module pixel_writeback_packer
  import ipu_pkg::*;
#(
  parameter logic [7:0]  FILL_BYTE = 8'h00,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic signed [15:0] pix_data,
  input  logic [H_W-1:0]     pix_h,
  input  logic [V_W-1:0]     pix_v,
  input  logic               frame_end,
  output logic               mem_req,
  input  logic               mem_grant,
  output logic               mem_we,
  output logic [TAG_W-1:0]   mem_addr,
  output logic [8*LANES-1:0] mem_data,
  output logic               busy,
  output logic [CNT_W-1:0]   words_written
);

  logic [1:0]         state_q, state_d;
  logic [LANES-1:0]   mask_q, mask_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [8*LANES-1:0] word_q, word_d;
  logic               pend_vld_q, pend_vld_d;
  pend_t              pend_q, pend_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               live_q;

  logic [7:0]         pix_byte;
  logic [TAG_W-1:0]   in_tag;
  logic [LANE_W-1:0]  in_lane;
  logic [LANES-1:0]   in_bit;
  logic               accept;
  logic               miss;

  pixel_clamp u_clamp (
    .pix_in  (pix_data),
    .pix_out (pix_byte)
  );

  assign in_tag    = {pix_v, pix_h[H_W-1:LANE_W]};
  assign in_lane   = pix_h[LANE_W-1:0];
  assign in_bit    = LANES'(1) << in_lane;
  // live_q holds ready low until the first clock edge after reset is released.
  assign pix_ready = live_q & (state_q == StAccum) & ~pend_vld_q;
  assign accept    = pix_valid & pix_ready;

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    tag_d      = tag_q;
    word_d     = word_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    miss       = 1'b0;
    unique case (state_q)
      StAccum: begin
        if (accept) begin
          if (mask_q == '0) begin
            tag_d  = in_tag;
            mask_d = in_bit;
            word_d = lane_insert({LANES{FILL_BYTE}}, in_lane, pix_byte);
          end else if (tag_q == in_tag) begin
            mask_d = mask_q | in_bit;
            word_d = lane_insert(word_q, in_lane, pix_byte);
          end else begin
            miss       = 1'b1;
            pend_vld_d = 1'b1;
            pend_d     = '{tag: in_tag, lane: in_lane, pix: pix_byte};
          end
        end
        if (miss || (mask_d == '1) || (frame_end && (mask_d != '0))) state_d = StReq;
      end
      StReq: begin
        if (mem_grant) state_d = StWrite;
      end
      StWrite: begin
        state_d = StAccum;
        cnt_d   = cnt_q + CNT_W'(1);
        // A pixel held back by a tag miss opens the next word as the write completes.
        if (pend_vld_q) begin
          pend_vld_d = 1'b0;
          tag_d      = pend_q.tag;
          mask_d     = LANES'(1) << pend_q.lane;
          word_d     = lane_insert({LANES{FILL_BYTE}}, pend_q.lane, pend_q.pix);
        end else begin
          mask_d = '0;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StAccum;
      mask_q     <= '0;
      tag_q      <= '0;
      word_q     <= '0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      cnt_q      <= '0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      tag_q      <= tag_d;
      word_q     <= word_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      live_q     <= 1'b1;
    end
  end

  assign mem_req       = (state_q == StReq);
  assign mem_we        = (state_q == StWrite);
  assign mem_addr      = tag_q;
  assign mem_data      = word_q;
  assign busy          = (mask_q != '0) | pend_vld_q | (state_q != StAccum);
  assign words_written = cnt_q;

endmodule

// File: doc/pixel_writeback_packer.md
PIXEL_WRITEBACK_PACKER -- requirements
Module: pixel_writeback_packer

Interface
REQ-001 Parameter FILL_BYTE, default 8'h00, value placed in unwritten byte lanes of a partially flushed word.
REQ-002 Parameter CNT_W, default 16, width of the words_written counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 pix_valid  in  1  convolution result available this cycle.
REQ-006 pix_ready  out  1  block accepts pixel; transfer = pix_valid & pix_ready.
REQ-007 pix_data  in  16  signed convolution result.
REQ-008 pix_h  in  9  pixel column, 0..511.
REQ-009 pix_v  in  9  pixel row, 0..479.
REQ-010 frame_end  in  1  one-cycle pulse; last pixel of frame sent.
REQ-011 mem_req  out  1  request for the shared frame-memory write port.
REQ-012 mem_grant  in  1  port granted (camera path idle).
REQ-013 mem_we  out  1  one-cycle write strobe.
REQ-014 mem_addr  out  16  word address {v[8:0], h[8:2]}.
REQ-015 mem_data  out  32  packed word, lane n at bits [8n+7:8n].
REQ-016 busy  out  1  high when any lane valid or a write is pending.
REQ-017 words_written  out  CNT_W  count of mem_we pulses, wraps at 2^CNT_W.

Function
REQ-018 Pixel conversion: signed pix_data clamped to 0..255 (negative -> 0, >255 -> 255) before storage.
REQ-019 Lane select = pix_h[1:0]; word tag = {pix_v, pix_h[8:2]}.
REQ-020 FSM states ACCUM, REQ, WRITE; pix_ready = (state==ACCUM) & !pending.
REQ-021 ACCUM, mask empty: accepted pixel opens word (tag latched, lane bit set).
REQ-022 ACCUM, tag hit: lane written; already-valid lane overwritten, no flush.
REQ-023 ACCUM, tag miss: accepted pixel held in one-entry pending register; current word flushed; pending pixel opens next word on return to ACCUM.
REQ-024 Transition ACCUM -> REQ on: mask becoming 4'hF, tag miss, or frame_end with mask != 0; frame_end with mask == 0 ignored.
REQ-025 frame_end coincident with accepted pixel: pixel merged first (or pended on miss), then flush.
REQ-026 REQ: mem_req=1, mem_addr/mem_data held; advance to WRITE on mem_grant.
REQ-027 WRITE: mem_we=1 exactly one cycle, mem_req=0, words_written++, mask cleared, return to ACCUM.
REQ-028 Latency: 4th lane accepted cycle N -> mem_req at N+1; grant at N+1 -> mem_we at N+2.
REQ-029 mem_addr/mem_data stable from REQ entry through WRITE; mem_we never asserted without preceding grant.
REQ-030 Unwritten lanes at flush = FILL_BYTE.
REQ-031 mem_grant outside REQ ignored; grant withdrawn in REQ keeps state REQ indefinitely.

Reset
REQ-032 reset asserted: state ACCUM, mask 0, pending 0, mem_req 0, mem_we 0, mem_addr 0, mem_data 0, busy 0, words_written 0, pix_ready 0.
REQ-033 pix_ready 1 from first clock after reset deassertion; reset mid-write discards word and pending pixel without a write.

Configuration
REQ-034 Macro PIXEL_WB_ABS_EN defined: pix_data replaced by its absolute value before clamp (edge-magnitude output); -32768 maps to 255.
REQ-035 Macro undefined: negative results clamp to 0 per REQ-018.

Structure
REQ-036 Shared package ipu_pkg holds FSM state encoding, lane count (4), tag/address field widths.
REQ-037 One combinational sub-module pixel_clamp (16-bit signed in, 8-bit out, abs option via macro).

Verification
REQ-038 Pixels h=0..3, v=5, data 10,20,30,40, grant tied 1 -> one write, addr 16'h0280, data 32'h281E140A, at N+2.
REQ-039 h=4,5 data 300,-7 then frame_end -> addr 16'h0001, data {FILL,FILL,00,FF}; with PIXEL_WB_ABS_EN data {FILL,FILL,07,FF}.
REQ-040 h=0 v=0 data 1, then h=8 v=0 data 2 -> write addr 0 data 32'h00000001, then h=8 pending opens addr 2; pix_ready low 2 cycles.
REQ-041 Full word, mem_grant held 0 for 10 cycles -> mem_req high 10 cycles, addr/data stable, no mem_we, pix_ready 0; grant -> single mem_we.
REQ-042 Reset asserted during REQ -> mem_req drops asynchronously, words_written 0, no mem_we after release.
